// File: rtl/aline_avg_capture.sv
// ---------------------------------------------------------------------------
// aline_avg_capture
// Captures one A-line of NSAMPLES ADC samples per sweep trigger into an
// internal line buffer. It can accumulate 2**AVG_LOG2 consecutive lines in
// place and then streams the averaged line out over a valid/ready handshake.
// All logic runs on the rising edge of clk_system.
//
// Ports
//   clk_system    in   system clock
//   global_reset  in   asynchronous active-high reset
//   acq_en        in   arm; triggers start a run from IDLE only when high
//   trigger       in   asynchronous sweep trigger level (rising edge = start)
//   adc_valid     in   qualifies adc_data
//   adc_data      in   two's-complement ADC sample
//   rd_ready      in   downstream accepts rd_data
//   rd_valid      out  rd_data valid
//   rd_data       out  averaged sample, optionally MSB-inverted
//   rd_last       out  final sample of the line
//   sample_pos    out  write address of the line being captured
//   acq_busy      out  high whenever the controller is not IDLE
//   missed_trig   out  saturating count of dropped triggers
// ---------------------------------------------------------------------------
module aline_avg_capture #(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned NSAMPLES   = 1170,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned OFFSET_BIN = 1
) (
  input  logic              clk_system,
  input  logic              global_reset,
  input  logic              acq_en,
  input  logic              trigger,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] sample_pos,
  output logic              acq_busy,
  output logic [15:0]       missed_trig
);

  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned LIDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NSAMPLES - 1);
  localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [DATA_W-1:0] MSB_FLIP  =
    (OFFSET_BIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CAPTURE   = 2'd1,
    S_WAIT_TRIG = 2'd2,
    S_READOUT   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_trig_s1;
  logic              r_trig_s2;
  logic              r_trig_d;
  logic [LIDX_W-1:0] r_line_idx;
  logic [ADDR_W-1:0] r_sample_pos;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_last;
  logic              r_acq_busy;
  logic [15:0]       r_missed;

  // Line buffer holds running sums; contents are don't-care after reset.
  logic [SUM_W-1:0]  r_mem [NSAMPLES];

  logic              w_trig_rise;
  logic              w_wr_en;
  logic [SUM_W-1:0]  w_sample_ext;
  logic [SUM_W-1:0]  w_rmw_old;
  logic [SUM_W-1:0]  w_wr_data;
  logic [SUM_W-1:0]  w_rd_word;
  logic signed [SUM_W-1:0] w_rd_shift;
  logic [DATA_W-1:0] w_rd_fmt;

  // Rising edge of the synchronised trigger.
  assign w_trig_rise = r_trig_s2 & ~r_trig_d;

  // Read-modify-write: the buffer is read asynchronously at the current write
  // address, so back-to-back samples to consecutive addresses never collide.
  assign w_wr_en      = (r_state == S_CAPTURE) && adc_valid;
  assign w_sample_ext = SUM_W'($signed(adc_data));
  assign w_rmw_old    = r_mem[r_sample_pos];
  assign w_wr_data    = (r_line_idx == '0) ? w_sample_ext
                                           : SUM_W'(w_rmw_old + w_sample_ext);

  // Average by arithmetic shift (rounds toward -inf), then format.
  assign w_rd_word  = r_mem[r_rd_addr];
  assign w_rd_shift = $signed(w_rd_word) >>> AVG_LOG2;
  assign w_rd_fmt   = w_rd_shift[DATA_W-1:0] ^ MSB_FLIP;

  // Line buffer write port.
  always_ff @(posedge clk_system) begin
    if (w_wr_en) begin
      r_mem[r_sample_pos] <= w_wr_data;
    end
  end

  // Controller: trigger sync, capture/average sequencing and readout.
  always_ff @(posedge clk_system or posedge global_reset) begin
    if (global_reset) begin
      r_state      <= S_IDLE;
      r_trig_s1    <= 1'b0;
      r_trig_s2    <= 1'b0;
      r_trig_d     <= 1'b0;
      r_line_idx   <= '0;
      r_sample_pos <= '0;
      r_rd_addr    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_last    <= 1'b0;
      r_acq_busy   <= 1'b0;
      r_missed     <= '0;
    end else begin
      r_trig_s1 <= trigger;
      r_trig_s2 <= r_trig_s1;
      r_trig_d  <= r_trig_s2;

      case (r_state)
        S_IDLE: begin
          if (w_trig_rise && acq_en) begin
            r_state      <= S_CAPTURE;
            r_line_idx   <= '0;
            r_sample_pos <= '0;
            r_acq_busy   <= 1'b1;
          end
        end

        S_CAPTURE: begin
          if (w_trig_rise && (r_missed != 16'hFFFF)) begin
            r_missed <= r_missed + 16'd1;
          end
          if (adc_valid) begin
            if (r_sample_pos == LAST_ADDR) begin
              r_sample_pos <= '0;
              if (r_line_idx == LAST_LINE) begin
                r_state   <= S_READOUT;
                r_rd_addr <= '0;
              end else begin
                r_line_idx <= r_line_idx + LIDX_W'(1);
                r_state    <= S_WAIT_TRIG;
              end
            end else begin
              r_sample_pos <= r_sample_pos + ADDR_W'(1);
            end
          end
        end

        S_WAIT_TRIG: begin
          // An averaging run always completes, so acq_en is not consulted.
          if (w_trig_rise) begin
            r_state <= S_CAPTURE;
          end
        end

        S_READOUT: begin
          if (w_trig_rise && (r_missed != 16'hFFFF)) begin
            r_missed <= r_missed + 16'd1;
          end
          // Output register reloads when empty or when its beat is taken.
          if (!r_rd_valid || rd_ready) begin
            if (r_rd_valid && r_rd_last) begin
              r_state    <= S_IDLE;
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_acq_busy <= 1'b0;
            end else begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= w_rd_fmt;
              r_rd_last  <= (r_rd_addr == LAST_ADDR);
              r_rd_addr  <= r_rd_addr + ADDR_W'(1);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_last     = r_rd_last;
  assign sample_pos  = r_sample_pos;
  assign acq_busy    = r_acq_busy;
  assign missed_trig = r_missed;

endmodule

// File: tb/tb_aline_avg_capture.sv
// ---------------------------------------------------------------------------
// tb_aline_avg_capture
// Directed bench for aline_avg_capture with 8-sample lines. Instance A uses
// no averaging, instance B averages 4 lines; a select steers the trigger and
// arm inputs and picks which instance's outputs are observed.
// ---------------------------------------------------------------------------
module tb_aline_avg_capture;

  localparam int unsigned DW = 14;
  localparam int unsigned NS = 8;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst;
  logic          trig;
  logic          acq_en;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          rd_ready;
  logic          sel;

  logic          trig_a, trig_b, en_a, en_b;
  logic          valid_a, valid_b, last_a, last_b, busy_a, busy_b;
  logic [DW-1:0] data_a, data_b;
  logic [AW-1:0] pos_a, pos_b;
  logic [15:0]   miss_a, miss_b;

  logic          o_valid, o_last, o_busy;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_pos;
  logic [15:0]   o_miss;

  int            n_tests;
  int            n_fail;
  int            line_vals [NS];
  logic [DW-1:0] exp_line  [NS];
  logic [3:0]    ready_pat;

  assign trig_a  = trig & ~sel;
  assign trig_b  = trig & sel;
  assign en_a    = acq_en & ~sel;
  assign en_b    = acq_en & sel;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_last  = sel ? last_b  : last_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_data  = sel ? data_b  : data_a;
  assign o_pos   = sel ? pos_b   : pos_a;
  assign o_miss  = sel ? miss_b  : miss_a;

  aline_avg_capture #(.DATA_W(DW), .NSAMPLES(NS), .ADDR_W(AW), .AVG_LOG2(0), .OFFSET_BIN(1)) u_dut_a (
    .clk_system(clk), .global_reset(rst), .acq_en(en_a), .trigger(trig_a),
    .adc_valid(adc_valid), .adc_data(adc_data), .rd_ready(rd_ready),
    .rd_valid(valid_a), .rd_data(data_a), .rd_last(last_a),
    .sample_pos(pos_a), .acq_busy(busy_a), .missed_trig(miss_a)
  );

  aline_avg_capture #(.DATA_W(DW), .NSAMPLES(NS), .ADDR_W(AW), .AVG_LOG2(2), .OFFSET_BIN(1)) u_dut_b (
    .clk_system(clk), .global_reset(rst), .acq_en(en_b), .trigger(trig_b),
    .adc_valid(adc_valid), .adc_data(adc_data), .rd_ready(rd_ready),
    .rd_valid(valid_b), .rd_data(data_b), .rd_last(last_b),
    .sample_pos(pos_b), .acq_busy(busy_b), .missed_trig(miss_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Raise the trigger; on return the selected DUT has just entered CAPTURE.
  task automatic do_trigger();
    trig = 1'b1;
    repeat (3) @(negedge clk);
    trig = 1'b0;
  endtask

  // Stream the first n entries of line_vals, one per cycle.
  task automatic feed(input int n, input bit mid_trig);
    for (int i = 0; i < n; i++) begin
      chk("sample_pos", 32'(o_pos), 32'(i));
      if (mid_trig) begin
        if (i == 2) trig = 1'b1;
        if (i == 5) trig = 1'b0;
      end
      adc_valid = 1'b1;
      adc_data  = DW'(line_vals[i]);
      @(negedge clk);
    end
    adc_valid = 1'b0;
    adc_data  = '0;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NS; i++) line_vals[i] = v;
  endtask

  task automatic exp_const(input logic [DW-1:0] v);
    for (int i = 0; i < NS; i++) exp_line[i] = v;
  endtask

  // Drain one readout against exp_line, optionally stalling and triggering.
  task automatic collect(input bit stall, input bit mid_trig);
    int            beat;
    int            k;
    bit            stalled;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    beat    = 0;
    k       = 0;
    stalled = 1'b0;
    hold_d  = '0;
    hold_l  = 1'b0;
    while (beat < NS && k < 200) begin
      rd_ready = stall ? ready_pat[k % 4] : 1'b1;
      if (mid_trig) trig = (k >= 1 && k < 4);
      if (stalled) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_data", 32'(o_data), 32'(hold_d));
        chk("stall_last", 32'(o_last), 32'(hold_l));
      end
      stalled = 1'b0;
      if (o_valid) begin
        if (rd_ready) begin
          chk("rd_data", 32'(o_data), 32'(exp_line[beat]));
          chk("rd_last", 32'(o_last), 32'(beat == NS - 1));
          beat++;
        end else begin
          stalled = 1'b1;
          hold_d  = o_data;
          hold_l  = o_last;
        end
      end
      k++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    trig     = 1'b0;
    chk("beat_count", 32'(beat), 32'(NS));
    chk("valid_after", 32'(o_valid), 32'd0);
    chk("busy_after", 32'(o_busy), 32'd0);
  endtask

  task automatic chk_reset_state();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_pos", 32'(o_pos), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_miss", 32'(o_miss), 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    ready_pat = 4'b1001;
    sel       = 1'b0;
    rst       = 1'b1;
    trig      = 1'b0;
    acq_en    = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    rd_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_state();
    sel = 1'b1;
    #1;
    chk_reset_state();
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    @(negedge clk);

    // Ramp 0..7, no averaging; busy rises on the third edge after the trigger.
    acq_en = 1'b1;
    trig   = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_busy_pre", 32'(o_busy), 32'd0);
    @(negedge clk);
    chk("t1_busy", 32'(o_busy), 32'd1);
    trig = 1'b0;
    for (int i = 0; i < NS; i++) line_vals[i] = i;
    feed(NS, 1'b0);
    chk("t1_pos_wrap", 32'(o_pos), 32'd0);
    exp_line[0] = 14'h2000; exp_line[1] = 14'h2001; exp_line[2] = 14'h2002; exp_line[3] = 14'h2003;
    exp_line[4] = 14'h2004; exp_line[5] = 14'h2005; exp_line[6] = 14'h2006; exp_line[7] = 14'h2007;
    collect(1'b0, 1'b0);
    chk("t1_miss", 32'(o_miss), 32'd0);

    // Stalled readout plus one stray trigger in capture and one in readout.
    line_vals[0] = -8192; line_vals[1] = -1; line_vals[2] = 0;  line_vals[3] = 1;
    line_vals[4] = 8191;  line_vals[5] = 5;  line_vals[6] = -5; line_vals[7] = 100;
    exp_line[0] = 14'h0000; exp_line[1] = 14'h1FFF; exp_line[2] = 14'h2000; exp_line[3] = 14'h2001;
    exp_line[4] = 14'h3FFF; exp_line[5] = 14'h2005; exp_line[6] = 14'h1FFB; exp_line[7] = 14'h2064;
    do_trigger();
    feed(NS, 1'b1);
    chk("t4_miss_cap", 32'(o_miss), 32'd1);
    collect(1'b1, 1'b1);
    chk("t4_miss", 32'(o_miss), 32'd2);

    // Instance B: trigger while disarmed is ignored and not counted.
    acq_en = 1'b0;
    sel    = 1'b1;
    @(negedge clk);
    do_trigger();
    repeat (2) @(negedge clk);
    chk("t5_busy", 32'(o_busy), 32'd0);
    chk("t5_miss", 32'(o_miss), 32'd0);
    chk("t5_pos", 32'(o_pos), 32'd0);

    // Four-line average of 100, 200, -100, 0 -> 50.
    acq_en = 1'b1;
    for (int ln = 0; ln < 4; ln++) begin
      case (ln)
        0: fill_const(100);
        1: fill_const(200);
        2: fill_const(-100);
        default: fill_const(0);
      endcase
      do_trigger();
      feed(NS, 1'b0);
      if (ln < 3) begin
        repeat (2) @(negedge clk);
        chk("t2_busy_between", 32'(o_busy), 32'd1);
        chk("t2_valid_between", 32'(o_valid), 32'd0);
      end
    end
    exp_const(14'h2032);
    collect(1'b0, 1'b0);

    // Disarm mid-run; negative sums round toward -inf.
    line_vals[0] = -1; line_vals[1] = -2; line_vals[2] = -3; line_vals[3] = -4;
    line_vals[4] = -5; line_vals[5] = -6; line_vals[6] = -7; line_vals[7] = 1;
    do_trigger();
    feed(NS, 1'b0);
    acq_en = 1'b0;
    fill_const(0);
    for (int ln = 1; ln < 4; ln++) begin
      do_trigger();
      feed(NS, 1'b0);
    end
    exp_line[0] = 14'h1FFF; exp_line[1] = 14'h1FFF; exp_line[2] = 14'h1FFF; exp_line[3] = 14'h1FFF;
    exp_line[4] = 14'h1FFE; exp_line[5] = 14'h1FFE; exp_line[6] = 14'h1FFE; exp_line[7] = 14'h2000;
    collect(1'b0, 1'b0);
    chk("t5_miss_end", 32'(o_miss), 32'd0);

    // Reset during the second line of a run, then a clean four-line run.
    acq_en = 1'b1;
    fill_const(40);
    do_trigger();
    feed(NS, 1'b0);
    fill_const(7);
    do_trigger();
    feed(3, 1'b0);
    rst = 1'b1;
    #1;
    chk_reset_state();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int ln = 0; ln < 4; ln++) begin
      fill_const(4 * (ln + 1));
      do_trigger();
      feed(NS, 1'b0);
    end
    exp_const(14'h200A);
    collect(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
